// File: rtl/nand_logic_pipe_if.sv
// Streaming handshake bundle for the nand-built logic pipe.
// The master side offers operand beats and accepts results; the slave side is the pipe itself.
interface nand_logic_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_last;

    modport master (
        output in_valid, op, a, b, acc, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_last
    );

    modport slave (
        input  in_valid, op, a, b, acc, in_last, out_ready,
        output in_ready, out_valid, out_y, out_last
    );
endinterface

// File: rtl/nand_logic_pipe.sv
// Two-stage pipelined bitwise logic unit. Stage 1 captures the beat, stage 2 evaluates one of
// eight two-operand functions through a network of 2-input nand primitives and holds the result.
// An optional accumulate mode folds a burst into a single result emitted on its last beat.
module nand_logic_pipe #(
    parameter int WIDTH  = 8,
    parameter int ACC_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    nand_logic_pipe_if.slave   bus
);
    localparam logic ACC_ON = (ACC_EN != 0);

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_acc;
    logic             s1_last;
    logic             acc_active;
    logic [WIDTH-1:0] acc_reg;

    logic             s2_free;
    logic             s2_adv;
    logic             in_fire;
    logic [WIDTH-1:0] x;
    wire  [WIDTH-1:0] r;

    assign s2_free     = !bus.out_valid || bus.out_ready;
    assign s2_adv      = s1_valid && s2_free;
    assign bus.in_ready = !s1_valid || s2_free;
    assign in_fire     = bus.in_valid && bus.in_ready;
    assign x           = (s1_acc && acc_active) ? acc_reg : s1_a;

    // Op decode: inverted select bits and one-hot selects, all from nand gates.
    wire [2:0] opn;
    wire [7:0] sel;
    nand u_opn0 (opn[0], s1_op[0], s1_op[0]);
    nand u_opn1 (opn[1], s1_op[1], s1_op[1]);
    nand u_opn2 (opn[2], s1_op[2], s1_op[2]);

    wire [1:0] lit0 = {s1_op[0], opn[0]};
    wire [1:0] lit1 = {s1_op[1], opn[1]};
    wire [1:0] lit2 = {s1_op[2], opn[2]};

    genvar i, k;
    for (k = 0; k < 8; k++) begin : g_dec
        localparam logic [2:0] KB = 3'(k);
        wire t21n, t21, seln;
        nand u_t21n (t21n, lit2[KB[2]], lit1[KB[1]]);
        nand u_t21  (t21, t21n, t21n);
        nand u_seln (seln, t21, lit0[KB[0]]);
        nand u_sel  (sel[k], seln, seln);
    end

    // Per-bit function network and 8:1 nand mux; bit i depends only on bit i of x and s1_b.
    for (i = 0; i < WIDTH; i++) begin : g_bit
        wire xi = x[i];
        wire yi = s1_b[i];
        wire f_nand, f_and, nx, ny, f_or, f_nor, t1, t2, f_xor, f_xnor, f_pass;
        nand u_nand (f_nand, xi, yi);
        nand u_and  (f_and, f_nand, f_nand);
        nand u_nx   (nx, xi, xi);
        nand u_ny   (ny, yi, yi);
        nand u_or   (f_or, nx, ny);
        nand u_nor  (f_nor, f_or, f_or);
        nand u_t1   (t1, xi, f_nand);
        nand u_t2   (t2, yi, f_nand);
        nand u_xor  (f_xor, t1, t2);
        nand u_xnor (f_xnor, f_xor, f_xor);
        nand u_pass (f_pass, nx, nx);

        wire [7:0] fv = {f_pass, nx, f_xnor, f_xor, f_nor, f_or, f_and, f_nand};
        wire [7:0] p;
        for (k = 0; k < 8; k++) begin : g_term
            nand u_p (p[k], sel[k], fv[k]);
        end

        wire w01n, w01, w23n, w23, w45n, w45, w67n, w67, w03n, w03, w47n, w47;
        nand u_w01n (w01n, p[0], p[1]);
        nand u_w01  (w01, w01n, w01n);
        nand u_w23n (w23n, p[2], p[3]);
        nand u_w23  (w23, w23n, w23n);
        nand u_w45n (w45n, p[4], p[5]);
        nand u_w45  (w45, w45n, w45n);
        nand u_w67n (w67n, p[6], p[7]);
        nand u_w67  (w67, w67n, w67n);
        nand u_w03n (w03n, w01, w23);
        nand u_w03  (w03, w03n, w03n);
        nand u_w47n (w47n, w45, w67);
        nand u_w47  (w47, w47n, w47n);
        nand u_r    (r[i], w03, w47);
    end

    // Stage 1: capture an accepted beat, or empty out once stage 2 takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_acc   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= bus.op;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_acc   <= bus.acc && ACC_ON;
            s1_last  <= bus.in_last;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: fold into the accumulator mid-chain, otherwise publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_y     <= '0;
            bus.out_last  <= 1'b0;
            acc_active    <= 1'b0;
            acc_reg       <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (s2_adv) begin
                if (s1_acc && !s1_last) begin
                    acc_reg    <= r;
                    acc_active <= 1'b1;
                end else begin
                    bus.out_y     <= r;
                    bus.out_last  <= s1_last;
                    bus.out_valid <= 1'b1;
                    acc_active    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_nand_logic_pipe.sv
// Directed bench for nand_logic_pipe: one instance with accumulate enabled, one without.
// Expected results are queued when a beat is accepted and popped when the result leaves.
module tb_nand_logic_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nand_logic_pipe_if #(.WIDTH(W)) bus0 ();
    nand_logic_pipe_if #(.WIDTH(W)) bus1 ();

    nand_logic_pipe #(.WIDTH(W), .ACC_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    nand_logic_pipe #(.WIDTH(W), .ACC_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;
    logic [W:0] q0[$];
    logic [W:0] q1[$];
    logic       act[2];
    logic [W-1:0] accr[2];
    int cyc = 0;
    int out_cnt0 = 0;
    int out_cnt1 = 0;
    int in_cnt0 = 0;
    int first_out = -1;
    int last_out = -1;
    logic fired0;

    function automatic logic [W-1:0] f_model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        case (op)
            3'd0: return ~(x & y);
            3'd1: return x & y;
            3'd2: return x | y;
            3'd3: return ~(x | y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int d, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acc, input logic last);
        logic eff;
        logic [W-1:0] x;
        logic [W-1:0] r;
        eff = acc && (d == 0);
        x = (eff && act[d]) ? accr[d] : a;
        r = f_model(op, x, b);
        if (eff && !last) begin
            accr[d] = r;
            act[d] = 1'b1;
        end else begin
            act[d] = 1'b0;
            if (d == 0) q0.push_back({last, r});
            else q1.push_back({last, r});
        end
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        act[0] = 1'b0;
        act[1] = 1'b0;
        accr[0] = '0;
        accr[1] = '0;
    endtask

    task automatic cycle();
        logic [W:0] e;
        #1;
        fired0 = bus0.in_valid && bus0.in_ready;
        if (fired0) begin
            in_cnt0++;
            accept(0, bus0.op, bus0.a, bus0.b, bus0.acc, bus0.in_last);
        end
        if (bus1.in_valid && bus1.in_ready)
            accept(1, bus1.op, bus1.a, bus1.b, bus1.acc, bus1.in_last);
        if (bus0.out_valid && bus0.out_ready) begin
            out_cnt0++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            check("out0_pending", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("y0", bus0.out_y, e[W-1:0]);
                check("last0", bus0.out_last, e[W]);
            end
        end
        if (bus1.out_valid && bus1.out_ready) begin
            out_cnt1++;
            check("out1_pending", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("y1", bus1.out_y, e[W-1:0]);
                check("last1", bus1.out_last, e[W]);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ac, input logic la);
        bus0.in_valid = v; bus0.op = o; bus0.a = aa; bus0.b = bb; bus0.acc = ac; bus0.in_last = la;
    endtask

    task automatic drive1(input logic v, input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ac, input logic la);
        bus1.in_valid = v; bus1.op = o; bus1.a = aa; bus1.b = bb; bus1.acc = ac; bus1.in_last = la;
    endtask

    task automatic drain();
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) cycle();
        cycle();
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
    endtask

    logic [2:0]   bp_op[3] = '{3'd7, 3'd4, 3'd1};
    logic [W-1:0] bp_a[3]  = '{8'h5A, 8'h3C, 8'hF0};
    logic [W-1:0] bp_b[3]  = '{8'h00, 8'hFF, 8'h0F};

    initial begin
        int sent;
        int base;
        logic [W-1:0] held;
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        clear_model();

        // Power-on reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_out_y", bus0.out_y, 0);
        check("rst_out_last", bus0.out_last, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus0.in_ready, 1);

        // Two-edge latency
        drive0(1, 3'd1, 8'h3C, 8'hF0, 0, 1);
        cycle();
        bus0.in_valid = 1'b0;
        check("lat_edge1", bus0.out_valid, 0);
        cycle();
        check("lat_edge2", bus0.out_valid, 1);
        drain();

        // Op sweep on CC/AA
        for (int k = 0; k < 8; k++) begin
            drive0(1, 3'(k), 8'hCC, 8'hAA, 0, k == 7);
            cycle();
        end
        drain();

        // Backpressure: only two beats fit while the output is stalled
        bus0.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            drive0(1, bp_op[sent], bp_a[sent], bp_b[sent], 0, sent == 2);
            cycle();
            if (fired0) sent++;
            if (c == 2) held = bus0.out_y;
        end
        check("bp_accepted", sent, 2);
        check("bp_in_ready", bus0.in_ready, 0);
        check("bp_out_valid", bus0.out_valid, 1);
        check("bp_out_y_model", bus0.out_y, q0[0][W-1:0]);
        check("bp_out_y_held", bus0.out_y, held);
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            drive0(1, bp_op[sent], bp_a[sent], bp_b[sent], 0, sent == 2);
            cycle();
            if (fired0) sent++;
        end
        check("bp_sent_all", sent, 3);
        drain();

        // Accumulate XOR chain; a on later beats must be ignored
        base = out_cnt0;
        drive0(1, 3'd4, 8'h0F, 8'hF0, 1, 0); cycle();
        drive0(1, 3'd4, 8'h55, 8'hFF, 1, 0); cycle();
        drive0(1, 3'd4, 8'hAA, 8'h01, 1, 1); cycle();
        drain();
        check("acc_out_count", out_cnt0 - base, 1);

        // Throughput: 16 back-to-back beats
        out_cnt0 = 0;
        in_cnt0 = 0;
        first_out = -1;
        last_out = -1;
        for (int i = 0; i < 16; i++) begin
            drive0(1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 0, i == 15);
            cycle();
        end
        drain();
        check("tp_accepts", in_cnt0, 16);
        check("tp_outputs", out_cnt0, 16);
        check("tp_span", last_out - first_out, 15);

        // Chain abort by a non-accumulate beat
        base = out_cnt0;
        drive0(1, 3'd2, 8'h01, 8'h02, 1, 0); cycle();
        drive0(1, 3'd1, 8'hF0, 8'h3C, 0, 1); cycle();
        drain();
        check("abort_out_count", out_cnt0 - base, 1);
        check("abort_acc_active", dut0.acc_active, 0);

        // Same XOR chain with accumulate disabled
        base = out_cnt1;
        drive1(1, 3'd4, 8'h0F, 8'hF0, 1, 0); cycle();
        drive1(1, 3'd4, 8'h00, 8'hFF, 1, 0); cycle();
        drive1(1, 3'd4, 8'h00, 8'h01, 1, 1); cycle();
        drain();
        check("noacc_out_count", out_cnt1 - base, 3);

        // Reset mid-stream while a result is pending
        bus0.out_ready = 1'b0;
        drive0(1, 3'd7, 8'h5A, 8'h00, 0, 1); cycle();
        drive0(1, 3'd7, 8'hA5, 8'h00, 1, 0); cycle();
        bus0.in_valid = 1'b0;
        check("mid_pre_valid", bus0.out_valid, 1);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("mid_out_valid", bus0.out_valid, 0);
        check("mid_out_y", bus0.out_y, 0);
        check("mid_out_last", bus0.out_last, 0);
        check("mid_acc_active", dut0.acc_active, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_in_ready", bus0.in_ready, 1);
        base = out_cnt0;
        bus0.out_ready = 1'b1;
        repeat (4) cycle();
        check("mid_no_output", out_cnt0 - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
